uart_lcd_scheduler: RTL and testbench
=====================================

Name: uart_lcd_scheduler

Overview:
Sequences the UART receive FIFO into a 32-character display RAM that the LCD1602 controller scans. It pops bytes only when the FIFO has data, interprets terminal control codes (CR, LF, FF), and writes printable characters at a cursor position. It issues refresh requests to the LCD controller, handshaking on the controller's busy flag. It sits between the UART FIFO and the LCD1602 controller, replacing the fixed one-cycle-delayed auto-read.

Parameters:
DATA_BITS, 8, byte width of FIFO data and characters
NUM_CHARS, 32, display RAM depth; must be 2*LINE_LEN
LINE_LEN, 16, characters per LCD line
REFRESH_MAX, 2500000, maximum cycles a pending update may wait during a continuous stream (50 ms at 50 MHz)

Ports:
clk_50MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
fifo_empty  in  1  FIFO empty flag
fifo_data  in  DATA_BITS  FIFO head byte; first-word-fall-through, valid while fifo_empty=0
fifo_rd  out  1  one-cycle pop pulse
lcd_busy  in  1  LCD controller is mid-refresh
lcd_refresh  out  1  one-cycle refresh request
char_wr_en  out  1  display RAM write strobe
char_addr  out  5  display RAM address (0-15 line 0, 16-31 line 1)
char_data  out  DATA_BITS  display RAM write data
cursor  out  5  current cursor position
drop_cnt  out  8  count of discarded non-printable bytes, saturating at 255

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; dirty=0; refresh timer=0.
- States: IDLE, POP, WRITE, CLEAR, REFRESH.
- IDLE:
  - If fifo_empty=0: latch fifo_data, assert fifo_rd for exactly 1 cycle, go to POP.
  - Else if dirty=1 and lcd_busy=0: go to REFRESH.
- POP (decode the latched byte):
  - 0x20-0x7E: go to WRITE.
  - 0x0D (CR): cursor <= cursor with bits[3:0] cleared (start of current line); dirty=1; go to IDLE.
  - 0x0A (LF): cursor <= 16 if cursor<16, else 0; dirty=1; go to IDLE.
  - 0x0C (FF): clear counter=0; go to CLEAR.
  - Any other byte: drop_cnt++ (saturating); go to IDLE; dirty unchanged.
- WRITE: char_wr_en=1 for 1 cycle, char_addr=cursor, char_data=latched byte; cursor <= cursor+1 mod 32 (31 wraps to 0); dirty=1; go to IDLE.
- CLEAR:
  - 32 consecutive cycles of char_wr_en=1, char_data=0x20, char_addr=0..31.
  - Then cursor=0, dirty=1, go to IDLE.
  - No FIFO pops during CLEAR; incoming bytes stay in the FIFO.
- REFRESH:
  - Wait while lcd_busy=1.
  - On the first cycle with lcd_busy=0: lcd_refresh=1 for 1 cycle; dirty=0; timer=0; go to IDLE.
- Refresh timer:
  - Counts every cycle while dirty=1; holds at 0 while dirty=0.
  - When it reaches REFRESH_MAX-1, the IDLE refresh condition is taken even if fifo_empty=0, so a continuous stream still updates the display. This forced refresh still waits on lcd_busy.
- Throughput: printable byte = 3 cycles IDLE→IDLE (IDLE, POP, WRITE); control byte = 2 cycles; FF = 2+32 cycles.
- fifo_rd is never asserted while fifo_empty=1. At most one pop is in flight at a time.
- lcd_refresh is never asserted while lcd_busy=1.
- Reset asserted mid-CLEAR or mid-REFRESH aborts immediately. The RAM is left partially written; no refresh is issued.

Optional Feature:
HEX_DUMP_EN
- Defined:
  - POP treats every byte as data; no control decoding, and drop_cnt stays 0.
  - Each byte is written as two uppercase ASCII hex digits, high nibble first, in two consecutive WRITE cycles. The cursor advances by 2 with mod-32 wrap.
  - Printable byte rate becomes 4 cycles per byte.
- Not defined: control-code behaviour as specified in Behaviour.

Test Plan:
- Reset then FIFO presents "HI": pops at 2 distinct cycles → writes (0,0x48),(1,0x49), cursor=2, then one lcd_refresh once FIFO is empty with lcd_busy=0.
- 33 printable bytes 'A'..: write #33 goes to addr 0 → wrap verified, cursor=1.
- Cursor=5, then bytes 0x0D,0x0A,'X' → 'X' at addr 16, cursor=17. Second LF from cursor 17 → cursor=0.
- Byte 0x0C with 3 more bytes queued behind it → 32 writes of 0x20 at addr 0..31, fifo_rd low throughout, then the queued bytes are written from addr 0.
- lcd_busy held high 100 cycles with dirty=1 → lcd_refresh stays 0, then pulses 1 cycle after lcd_busy falls. Bytes 0x01, 0x7F → drop_cnt=2, no writes.
- Continuous stream with REFRESH_MAX=64 → lcd_refresh within 64 cycles of the first write despite fifo_empty=0. HEX_DUMP_EN build: byte 0x3A → writes '3','A' at addrs 0,1.

Source files
------------

// File: rtl/uart_lcd_scheduler.sv
// uart_lcd_scheduler: pops the UART RX FIFO, decodes CR/LF/FF, writes the
// 32-char LCD RAM at the cursor and requests refreshes from the LCD driver.
//
// Ports:
//   clk_50MHz, reset         clock, async active-high reset
//   fifo_empty, fifo_data    FWFT FIFO head; fifo_rd is a 1-cycle pop
//   lcd_busy, lcd_refresh    refresh request, only issued when not busy
//   char_wr_en/addr/data     display RAM write port
//   cursor, drop_cnt         cursor position, saturating dropped-byte count
//
// Build option HEX_DUMP_EN: every byte is shown as two uppercase hex digits.
module uart_lcd_scheduler #(
    parameter int DATA_BITS   = 8,
    parameter int NUM_CHARS   = 32,
    parameter int LINE_LEN    = 16,
    parameter int REFRESH_MAX = 2500000
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd,
    input  logic                 lcd_busy,
    output logic                 lcd_refresh,
    output logic                 char_wr_en,
    output logic [4:0]           char_addr,
    output logic [DATA_BITS-1:0] char_data,
    output logic [4:0]           cursor,
    output logic [7:0]           drop_cnt
);

    localparam int TW = $clog2(REFRESH_MAX);
    localparam logic [TW-1:0] T_LAST = TW'(REFRESH_MAX - 1);
    localparam logic [DATA_BITS-1:0] CH_SPACE = DATA_BITS'(8'h20);
    localparam logic [4:0] LAST_ADDR = 5'(NUM_CHARS - 1);
    localparam logic [4:0] LINE_A    = 5'(LINE_LEN);
    localparam logic [4:0] COL_MASK  = 5'(LINE_LEN - 1);

`ifdef HEX_DUMP_EN
    function automatic logic [DATA_BITS-1:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? DATA_BITS'(8'h30 + 8'(n))
                               : DATA_BITS'(8'h37 + 8'(n));
    endfunction
`else
    localparam logic [DATA_BITS-1:0] CH_TILDE = DATA_BITS'(8'h7E);
    localparam logic [DATA_BITS-1:0] CH_CR    = DATA_BITS'(8'h0D);
    localparam logic [DATA_BITS-1:0] CH_LF    = DATA_BITS'(8'h0A);
    localparam logic [DATA_BITS-1:0] CH_FF    = DATA_BITS'(8'h0C);
`endif

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WRITE,
        CLEAR,
        REFRESH
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] byte_q;
    logic [4:0]           clr_cnt;
    logic                 dirty;
    logic [TW-1:0]        timer;
    logic                 force_ref;
`ifdef HEX_DUMP_EN
    logic                 nib_lo;
`endif

    // A stream that never drains would otherwise starve the display.
    assign force_ref = dirty && (timer == T_LAST);

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            byte_q      <= '0;
            clr_cnt     <= '0;
            dirty       <= 1'b0;
            timer       <= '0;
            fifo_rd     <= 1'b0;
            lcd_refresh <= 1'b0;
            char_wr_en  <= 1'b0;
            char_addr   <= '0;
            char_data   <= '0;
            cursor      <= '0;
            drop_cnt    <= '0;
`ifdef HEX_DUMP_EN
            nib_lo      <= 1'b0;
`endif
        end else begin
            fifo_rd     <= 1'b0;
            lcd_refresh <= 1'b0;
            if (!dirty)
                timer <= '0;
            else if (timer != T_LAST)
                timer <= timer + 1'b1;

            unique case (state)
                IDLE: begin
                    if (force_ref) begin
                        state <= REFRESH;
                    end else if (!fifo_empty) begin
                        byte_q  <= fifo_data;
                        fifo_rd <= 1'b1;
                        state   <= POP;
                    end else if (dirty && !lcd_busy) begin
                        state <= REFRESH;
                    end
                end
                POP: begin
`ifdef HEX_DUMP_EN
                    char_wr_en <= 1'b1;
                    char_addr  <= cursor;
                    char_data  <= hex_char(byte_q[7:4]);
                    nib_lo     <= 1'b0;
                    state      <= WRITE;
`else
                    unique case (1'b1)
                        (byte_q >= CH_SPACE && byte_q <= CH_TILDE): begin
                            char_wr_en <= 1'b1;
                            char_addr  <= cursor;
                            char_data  <= byte_q;
                            state      <= WRITE;
                        end
                        (byte_q == CH_CR): begin
                            cursor <= cursor & ~COL_MASK;
                            dirty  <= 1'b1;
                            state  <= IDLE;
                        end
                        (byte_q == CH_LF): begin
                            cursor <= (cursor < LINE_A) ? LINE_A : 5'd0;
                            dirty  <= 1'b1;
                            state  <= IDLE;
                        end
                        (byte_q == CH_FF): begin
                            clr_cnt    <= '0;
                            char_wr_en <= 1'b1;
                            char_addr  <= '0;
                            char_data  <= CH_SPACE;
                            state      <= CLEAR;
                        end
                        default: begin
                            if (drop_cnt != 8'hFF)
                                drop_cnt <= drop_cnt + 8'd1;
                            state <= IDLE;
                        end
                    endcase
`endif
                end
                WRITE: begin
`ifdef HEX_DUMP_EN
                    if (!nib_lo) begin
                        nib_lo    <= 1'b1;
                        char_addr <= cursor + 5'd1;
                        char_data <= hex_char(byte_q[3:0]);
                    end else begin
                        char_wr_en <= 1'b0;
                        cursor     <= cursor + 5'd2;
                        dirty      <= 1'b1;
                        state      <= IDLE;
                    end
`else
                    char_wr_en <= 1'b0;
                    cursor     <= cursor + 5'd1;
                    dirty      <= 1'b1;
                    state      <= IDLE;
`endif
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        char_wr_en <= 1'b0;
                        cursor     <= '0;
                        dirty      <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        clr_cnt   <= clr_cnt + 5'd1;
                        char_addr <= clr_cnt + 5'd1;
                    end
                end
                REFRESH: begin
                    if (!lcd_busy) begin
                        lcd_refresh <= 1'b1;
                        dirty       <= 1'b0;
                        timer       <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_lcd_scheduler.sv
// tb_uart_lcd_scheduler: FIFO model plus write scoreboard for
// uart_lcd_scheduler, with directed byte sequences.
`timescale 1ns/1ps
module tb_uart_lcd_scheduler;

    localparam int RMAX = 64;

    logic       clk_50MHz  = 1'b0;
    logic       reset      = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       lcd_busy   = 1'b0;
    logic       fifo_rd;
    logic       lcd_refresh;
    logic       char_wr_en;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic [4:0] cursor;
    logic [7:0] drop_cnt;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fq[$];
    wr_t        mon_e;
    int         tests = 0;
    int         fails = 0;
    int         n_rd  = 0;
    int         n_ref = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    uart_lcd_scheduler #(.REFRESH_MAX(RMAX)) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .lcd_busy   (lcd_busy),
        .lcd_refresh(lcd_refresh),
        .char_wr_en (char_wr_en),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .cursor     (cursor),
        .drop_cnt   (drop_cnt)
    );

    // Monitor: every RAM write is matched against the scoreboard.
    always @(negedge clk_50MHz) begin
        if (!reset) begin
            if (fifo_rd)
                n_rd++;
            if (lcd_refresh)
                n_ref++;
            if (fifo_rd && fifo_empty) begin
                fails++;
                $display("FAIL rd_when_empty fifo_rd=1 fifo_empty=1 want no pop");
            end
            if (lcd_refresh && lcd_busy) begin
                fails++;
                $display("FAIL refresh_when_busy lcd_refresh=1 lcd_busy=1 want 0");
            end
            if (char_wr_en) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_write got addr=%0d data=%02h want no write",
                             char_addr, char_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (char_addr !== mon_e.addr || char_data !== mon_e.data) begin
                        fails++;
                        $display("FAIL write got addr=%0d data=%02h want addr=%0d data=%02h",
                                 char_addr, char_data, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic step();
        logic p;
        @(posedge clk_50MHz);
        p = fifo_rd;
        #1;
        if (p && fq.size() > 0)
            void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        drive_fifo();
    endtask

    task automatic expect_wr(input int a, input logic [7:0] d);
        exp_q.push_back('{addr: 5'(a), data: d});
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        lcd_busy = 1'b0;
        fq.delete();
        exp_q.delete();
        drive_fifo();
        run(2);
        reset = 1'b0;
        run(2);
    endtask

    initial begin
        int   first_w;
        int   first_r;
        int   rd0;
        int   ref0;
        int   bad;
        int   spaces;
        logic nonempty;

        drive_fifo();
        run(3);
        check("rst_cursor", int'(cursor), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_strobes", int'({fifo_rd, lcd_refresh, char_wr_en}), 0);
        check("rst_addr_data", int'({char_addr, char_data}), 0);
        reset = 1'b0;
        run(2);

`ifdef HEX_DUMP_EN
        expect_wr(0, 8'h33);
        expect_wr(1, 8'h41);
        push(8'h3A);
        run(12);
        check("hex_cursor", int'(cursor), 2);
        check("hex_pending", exp_q.size(), 0);
        expect_wr(2, 8'h30);
        expect_wr(3, 8'h44);
        push(8'h0D);
        run(12);
        check("hex_cr_cursor", int'(cursor), 4);
        check("hex_drop_cnt", int'(drop_cnt), 0);
        check("hex_cr_pending", exp_q.size(), 0);
`else
        // "HI" then one refresh once the FIFO drains
        rd0  = n_rd;
        ref0 = n_ref;
        expect_wr(0, 8'h48);
        expect_wr(1, 8'h49);
        push(8'h48);
        push(8'h49);
        run(20);
        check("hi_pops", n_rd - rd0, 2);
        check("hi_cursor", int'(cursor), 2);
        check("hi_refresh_count", n_ref - ref0, 1);
        check("hi_pending", exp_q.size(), 0);

        // 33 printable bytes: wrap to addr 0, forced refresh mid-stream
        do_reset();
        first_w  = -1;
        first_r  = -1;
        nonempty = 1'b0;
        for (int i = 0; i < 33; i++) begin
            expect_wr(i % 32, 8'(65 + i));
            push(8'(65 + i));
        end
        for (int c = 0; c < 160; c++) begin
            step();
            if (char_wr_en && first_w < 0)
                first_w = c;
            if (lcd_refresh && first_r < 0) begin
                first_r  = c;
                nonempty = (fq.size() > 0);
            end
        end
        check("wrap_cursor", int'(cursor), 1);
        check("wrap_pending", exp_q.size(), 0);
        check("stream_refresh_seen", int'(first_r >= 0), 1);
        check("stream_refresh_latency",
              int'(first_r >= 0 && first_r - first_w <= RMAX + 4), 1);
        check("stream_fifo_nonempty", int'(nonempty), 1);

        // CR, LF, LF
        do_reset();
        for (int i = 0; i < 5; i++) begin
            expect_wr(i, 8'(97 + i));
            push(8'(97 + i));
        end
        run(25);
        check("crlf_cursor5", int'(cursor), 5);
        expect_wr(16, 8'h58);
        push(8'h0D);
        push(8'h0A);
        push(8'h58);
        run(20);
        check("crlf_cursor17", int'(cursor), 17);
        push(8'h0A);
        run(10);
        check("lf_wrap_cursor", int'(cursor), 0);
        check("crlf_pending", exp_q.size(), 0);

        // FF with three bytes queued behind it
        do_reset();
        for (int i = 0; i < 32; i++)
            expect_wr(i, 8'h20);
        expect_wr(0, 8'h31);
        expect_wr(1, 8'h32);
        expect_wr(2, 8'h33);
        rd0 = n_rd;
        push(8'h0C);
        push(8'h31);
        push(8'h32);
        push(8'h33);
        bad    = 0;
        spaces = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (spaces > 0 && spaces < 32 && fifo_rd)
                bad++;
            if (char_wr_en && char_data == 8'h20)
                spaces++;
            if (spaces > 0 && spaces < 32 && fifo_rd)
                bad++;
        end
        check("ff_space_writes", spaces, 32);
        check("ff_no_pop_in_clear", bad, 0);
        check("ff_pops", n_rd - rd0, 4);
        check("ff_cursor", int'(cursor), 3);
        check("ff_pending", exp_q.size(), 0);

        // refresh held off by lcd_busy, then drops
        do_reset();
        lcd_busy = 1'b1;
        ref0     = n_ref;
        expect_wr(0, 8'h5A);
        push(8'h5A);
        run(100);
        check("busy_no_refresh", n_ref - ref0, 0);
        lcd_busy = 1'b0;
        step();
        check("busy_release_pulse", int'(lcd_refresh), 1);
        step();
        check("busy_pulse_width", int'(lcd_refresh), 0);
        push(8'h01);
        push(8'h7F);
        run(15);
        check("drop_cnt", int'(drop_cnt), 2);
        check("drop_cursor", int'(cursor), 1);
        check("drop_pending", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
